health_manager: RTL

//  Owns both players' health state; drives HP1/HPP1/HP2/HPP2 for the health-bar renderer.
//  HP = live health (base bar). HPP = padded "trailing" health: holds after a hit, then drains to HP.

---
 rtl/health_pkg.sv | 17 +
 rtl/health_channel.sv | 129 ++++++++++++
 rtl/health_manager.sv | 102 ++++++++++
 3 files changed

// File: rtl/health_pkg.sv
// health_pkg: shared widths, channel FSM states and default tuning constants for the health manager
package health_pkg;

    localparam int HP_W            = 10;
    localparam int AMT_W           = 7;
    localparam int DEF_HP_MAX      = 100;
    localparam int DEF_HOLD_FRAMES = 30;
    localparam int DEF_DRAIN_DIV   = 2;

    typedef enum logic [1:0] {IDLE, HOLD, DRAIN, KO} hp_state_t;

    // Damage applied to a health value, floored at zero
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a, input logic [AMT_W-1:0] b);
        return (HP_W'(b) >= a) ? '0 : a - HP_W'(b);
    endfunction

endpackage

// File: rtl/health_channel.sv
// health_channel: one player's live/padded health, hold/drain FSM and K.O. flag (HEAL_EN adds heal inputs)
module health_channel
    import health_pkg::*;
#(
    parameter int HP_MAX      = DEF_HP_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int DRAIN_DIV   = DEF_DRAIN_DIV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             tick,
    input  logic             hit_valid,
    input  logic [AMT_W-1:0] hit_amt,
`ifdef HEAL_EN
    input  logic             heal_valid,
    input  logic [AMT_W-1:0] heal_amt,
`endif
    output logic [HP_W-1:0]  hp,
    output logic [HP_W-1:0]  hpp,
    output logic             ko
);

    localparam int CW = $clog2(HOLD_FRAMES + 1);
    localparam int DW = $clog2(DRAIN_DIV + 1);
    localparam logic [HP_W-1:0] FULL      = HP_W'(HP_MAX);
    localparam logic [CW-1:0]   HOLD_DONE = CW'(HOLD_FRAMES);
    localparam logic [CW-1:0]   HOLD_LAST = CW'(HOLD_FRAMES - 1);
    localparam logic [DW-1:0]   DIV_LAST  = DW'(DRAIN_DIV - 1);

    hp_state_t        state_q, state_d;
    logic [HP_W-1:0]  hp_q, hp_d, hpp_q, hpp_d;
    logic [CW-1:0]    hold_q, hold_d;
    logic [DW-1:0]    div_q, div_d;
    logic             ko_q, ko_d;
    logic             do_hit, do_heal;
    logic [AMT_W-1:0] dmg, gain;
    logic [HP_W-1:0]  hit_hp, heal_hp;
    logic [HP_W:0]    heal_sum;

`ifdef HEAL_EN
    // A same-cycle hit and heal collapse into their net; only a net loss counts as a hit
    assign do_hit  = hit_valid && (!heal_valid || hit_amt > heal_amt);
    assign do_heal = heal_valid && !do_hit;
    assign dmg     = heal_valid ? hit_amt - heal_amt : hit_amt;
    assign gain    = hit_valid ? heal_amt - hit_amt : heal_amt;
`else
    assign do_hit  = hit_valid;
    assign do_heal = 1'b0;
    assign dmg     = hit_amt;
    assign gain    = '0;
`endif

    assign hit_hp   = sat_sub(hp_q, dmg);
    assign heal_sum = {1'b0, hp_q} + (HP_W + 1)'(gain);
    assign heal_hp  = (heal_sum > (HP_W + 1)'(HP_MAX)) ? FULL : heal_sum[HP_W-1:0];

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            hp_q    <= FULL;
            hpp_q   <= FULL;
            hold_q  <= '0;
            div_q   <= '0;
            ko_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            hpp_q   <= hpp_d;
            hold_q  <= hold_d;
            div_q   <= div_d;
            ko_q    <= ko_d;
        end
    end

    // Next state: clear beats everything, then hit, then heal, then frame-paced hold/drain.
    // hold_q saturates at HOLD_FRAMES, which marks the drain phase for both DRAIN and KO.
    always_comb begin
        state_d = state_q;
        hp_d    = hp_q;
        hpp_d   = hpp_q;
        hold_d  = hold_q;
        div_d   = div_q;
        ko_d    = ko_q;
        if (clear) begin
            state_d = IDLE;
            hp_d    = FULL;
            hpp_d   = FULL;
            hold_d  = '0;
            div_d   = '0;
            ko_d    = 1'b0;
        end else if (state_q != KO && do_hit) begin
            hp_d    = hit_hp;
            ko_d    = (hit_hp == '0);
            state_d = (hit_hp == '0) ? KO : HOLD;
            hold_d  = '0;
            div_d   = '0;
        end else if (state_q != KO && do_heal) begin
            hp_d = heal_hp;
            if (heal_hp > hpp_q) begin
                hpp_d   = heal_hp;
                state_d = IDLE;
                hold_d  = '0;
                div_d   = '0;
            end
        end else if (state_q == DRAIN && hpp_q == hp_q) begin
            state_d = IDLE;
            hold_d  = '0;
            div_d   = '0;
        end else if (tick && state_q != IDLE) begin
            if (hold_q != HOLD_DONE) begin
                hold_d = hold_q + 1'b1;
                if (hold_q == HOLD_LAST && state_q == HOLD) state_d = DRAIN;
            end else if (hpp_q != hp_q) begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
                hpp_d = (div_q == DIV_LAST) ? hpp_q - 1'b1 : hpp_q;
            end
        end
    end

    // Outputs come straight from registers
    always_comb begin
        hp  = hp_q;
        hpp = hpp_q;
        ko  = ko_q;
    end

endmodule

// File: rtl/health_manager.sv
// health_manager: frame-tick detect, hit gating and round-over tracking around two health channels.
// Optional feature: define HEAL_EN to add heal1/heal2 ports.
module health_manager
    import health_pkg::*;
#(
    parameter int HP_MAX      = DEF_HP_MAX,
    parameter int HOLD_FRAMES = DEF_HOLD_FRAMES,
    parameter int DRAIN_DIV   = DEF_DRAIN_DIV
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic       frame_clk,
    input  logic       round_start,
    input  logic       dmg1_valid,
    input  logic [6:0] dmg1_amt,
    input  logic       dmg2_valid,
    input  logic [6:0] dmg2_amt,
`ifdef HEAL_EN
    input  logic       heal1_valid,
    input  logic [6:0] heal1_amt,
    input  logic       heal2_valid,
    input  logic [6:0] heal2_amt,
`endif
    output logic [9:0] HP1,
    output logic [9:0] HPP1,
    output logic [9:0] HP2,
    output logic [9:0] HPP2,
    output logic       ko1,
    output logic       ko2,
    output logic       round_over
);

    logic fc_q, fc_d, fc_prev_q, fc_prev_d;
    logic round_over_q, round_over_d;
    logic tick, hit1, hit2;
`ifdef HEAL_EN
    logic heal1, heal2;
`endif

    // Frame strobe sampling and sticky round-over flag
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            fc_q         <= 1'b0;
            fc_prev_q    <= 1'b0;
            round_over_q <= 1'b0;
        end else begin
            fc_q         <= fc_d;
            fc_prev_q    <= fc_prev_d;
            round_over_q <= round_over_d;
        end
    end

    // Edge detect, event gating and round-over condition on registered channel state
    always_comb begin
        fc_d         = frame_clk;
        fc_prev_d    = fc_q;
        tick         = fc_q & ~fc_prev_q;
        hit1         = dmg1_valid & ~round_over_q & ~round_start;
        hit2         = dmg2_valid & ~round_over_q & ~round_start;
`ifdef HEAL_EN
        heal1        = heal1_valid & ~round_over_q & ~round_start;
        heal2        = heal2_valid & ~round_over_q & ~round_start;
`endif
        round_over_d = round_start ? 1'b0
                     : round_over_q | ((ko1 | ko2) & (HPP1 == HP1) & (HPP2 == HP2));
    end

    assign round_over = round_over_q;

    health_channel #(.HP_MAX(HP_MAX), .HOLD_FRAMES(HOLD_FRAMES), .DRAIN_DIV(DRAIN_DIV)) u_p1 (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clear     (round_start),
        .tick      (tick),
        .hit_valid (hit1),
        .hit_amt   (dmg1_amt),
`ifdef HEAL_EN
        .heal_valid(heal1),
        .heal_amt  (heal1_amt),
`endif
        .hp        (HP1),
        .hpp       (HPP1),
        .ko        (ko1)
    );

    health_channel #(.HP_MAX(HP_MAX), .HOLD_FRAMES(HOLD_FRAMES), .DRAIN_DIV(DRAIN_DIV)) u_p2 (
        .clk       (Clk),
        .rst_n     (Reset_n),
        .clear     (round_start),
        .tick      (tick),
        .hit_valid (hit2),
        .hit_amt   (dmg2_amt),
`ifdef HEAL_EN
        .heal_valid(heal2),
        .heal_amt  (heal2_amt),
`endif
        .hp        (HP2),
        .hpp       (HPP2),
        .ko        (ko2)
    );

endmodule
